hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised ID-stage hazard detector for the ARM pipeline, successor to the single-entry EXE-load check.
//  Keeps a per-register pending scoreboard of in-flight writers and stalls IF/ID when a source operand is pending.
//  Supports multi-cycle data memory (several loads in flight), a forwarding/no-forwarding mode, branch-flush
//  cancellation and a saturating stall-cycle performance counter. Sits beside the ID stage; hazard drives the IF/ID freeze.
// PARAMETERS
//  NUM_REGS     16  architectural registers tracked; REG_AW = $clog2(NUM_REGS)
//  FWD_EN       1   1: only loads (mem_r_en) become pending; 0: every writer (wb_en) becomes pending
//  WB_BYPASS    1   1: register cleared by WB this cycle does not cause a hazard this cycle (negedge RF write)
//  MAX_OUTST    4   maximum simultaneously pending registers; CNT_W = $clog2(MAX_OUTST+1)
//  STALL_CNT_W  16  width of stall performance counter
// PORTS
//  clk          in   1            pipeline clock, all state on rising edge
//  rst          in   1            asynchronous, active-low reset
//  id_valid     in   1            ID holds a valid instruction
//  two_src      in   1            instruction reads src2 as well as src1
//  src1, src2   in   REG_AW       ID source registers
//  id_issue     in   1            ID instruction moves to EXE this cycle (id_valid & ~hazard & ~other freeze)
//  id_wb_en     in   1            issuing instruction writes a register
//  id_mem_r_en  in   1            issuing instruction is a load
//  id_dest      in   REG_AW       issuing instruction destination
//  wb_en        in   1            WB stage writes register file this cycle
//  wb_dest      in   REG_AW       WB destination
//  flush        in   1            branch taken: the instruction issued in the previous cycle is cancelled
//  hazard       out  1            stall IF/ID this cycle (combinational)
//  outstanding  out  CNT_W        number of pending registers (registered)
//  stall_cnt    out  STALL_CNT_W  cycles with hazard=1, saturating (registered)
// BEHAVIOUR
//  - Reset (rst=0, async): pending[]=0, outstanding=0, stall_cnt=0, last_issue_vld=0; hazard forced 0 while rst=0.
//  - track = id_issue & id_wb_en & (FWD_EN ? id_mem_r_en : 1); a tracked issue sets pending[id_dest] next edge.
//  - dep = pending[src1] | (two_src & pending[src2]); with WB_BYPASS=1 a pending bit equal to wb_dest with wb_en=1
//    is masked out of dep in the same cycle. src2 is ignored entirely when two_src=0.
//  - full = (outstanding == MAX_OUTST) & id_wb_en & (FWD_EN ? id_mem_r_en : 1) & ~pending[id_dest].
//  - hazard = id_valid & (dep | full). Zero latency (combinational from inputs and registered state).
//  - Clear: wb_en & pending[wb_dest] clears that bit next edge. Set and clear of same register same edge: set wins
//    (bit stays 1, outstanding unchanged). Set on an already-pending register: bit stays 1, no increment.
//  - outstanding = +1 per newly set bit, -1 per cleared bit, net 0 when both on different regs; never wraps
//    (set is impossible when full; assertion: no clear when 0).
//  - Flush: last_issue_vld/last_issue_dest record a tracked issue of the previous cycle. flush=1 with
//    last_issue_vld=1 clears pending[last_issue_dest] and decrements outstanding, unless a WB clear of the same
//    register already occurs that edge (single decrement). Flush has priority over a same-cycle set of that register
//    only for the old entry; an issue in the flush cycle is still ignored (id_issue must be 0 when flush=1).
//  - stall_cnt increments each cycle hazard=1; holds at 2^STALL_CNT_W-1.
//  - Reset mid-operation discards all pending state immediately; no pending bit survives reset.
// TESTING
//  1 FWD_EN=1: issue LDR r3; next cycle src1=3 -> hazard=1 until wb_en,wb_dest=3 cycle (hazard=0 that cycle, WB_BYPASS=1).
//  2 FWD_EN=0: issue ADD r5; src2=5, two_src=0 -> hazard=0; two_src=1 -> hazard=1; outstanding=1.
//  3 MAX_OUTST=4: issue loads r1..r4 -> outstanding=4; load to r6 -> hazard=1; wb r1 -> load r6 issues, outstanding=4.
//  4 Issue LDR r7, next cycle flush=1 -> pending[7]=0, outstanding decrements to previous value, src1=7 no hazard.
//  5 Same edge tracked issue r2 and wb_dest=2 with pending[2]=1 -> pending[2]=1, outstanding unchanged.
//  6 Hold dependency 70000 cycles (STALL_CNT_W=16) -> stall_cnt=65535; drop rst mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard detector: a per-register pending scoreboard of in-flight writers
// that freezes IF/ID when a source operand is still pending or the scoreboard is full.

module hazard_sb_entry (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic pend_o
);
  logic pend_q;

  // Set wins over clear so a re-issued writer keeps its register pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pend_q <= 1'b0;
    else if (set_i) pend_q <= 1'b1;
    else if (clr_i) pend_q <= 1'b0;
  end

  assign pend_o = pend_q;
endmodule

module hazard_scoreboard_unit #(
  parameter  int NUM_REGS    = 16,
  parameter  int FWD_EN      = 1,
  parameter  int WB_BYPASS   = 1,
  parameter  int MAX_OUTST   = 4,
  parameter  int STALL_CNT_W = 16,
  localparam int REG_AW      = $clog2(NUM_REGS),
  localparam int CNT_W       = $clog2(MAX_OUTST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic                   two_src,
  input  logic [REG_AW-1:0]      src1,
  input  logic [REG_AW-1:0]      src2,
  input  logic                   id_issue,
  input  logic                   id_wb_en,
  input  logic                   id_mem_r_en,
  input  logic [REG_AW-1:0]      id_dest,
  input  logic                   wb_en,
  input  logic [REG_AW-1:0]      wb_dest,
  input  logic                   flush,
  output logic                   hazard,
  output logic [CNT_W-1:0]       outstanding,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam logic [CNT_W-1:0]       MAX_C     = CNT_W'(MAX_OUTST);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  logic [NUM_REGS-1:0]    pending;
  logic [NUM_REGS-1:0]    set_vec, clr_vec, wb_oh, vis;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   last_vld_q, last_vld_d;
  logic [REG_AW-1:0]      last_dest_q, last_dest_d;
  logic                   kind_ok, track, dep, full;
  logic                   inc, wb_clr, fl_clr, fl_act;

  // Only the writer classes that cannot be forwarded occupy the scoreboard.
  assign kind_ok = (FWD_EN != 0) ? id_mem_r_en : 1'b1;
  assign track   = id_issue & id_wb_en & kind_ok & ~flush;
  assign fl_act  = flush & last_vld_q;

  assign wb_oh = wb_en ? (NUM_REGS'(1) << wb_dest) : '0;
  // A register written back this cycle is readable this cycle (RF writes on negedge).
  assign vis   = (WB_BYPASS != 0) ? (pending & ~wb_oh) : pending;
  assign dep   = vis[src1] | (two_src & vis[src2]);
  assign full  = (outstanding_q == MAX_C) & id_wb_en & kind_ok & ~pending[id_dest];

  assign hazard = rst & id_valid & (dep | full);

  assign set_vec = track ? (NUM_REGS'(1) << id_dest) : '0;
  assign clr_vec = wb_oh | (fl_act ? (NUM_REGS'(1) << last_dest_q) : '0);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk    (clk),
      .rst    (rst),
      .set_i  (set_vec[i]),
      .clr_i  (clr_vec[i]),
      .pend_o (pending[i])
    );
  end

  // Count only real bit transitions; a flush and WB on the same register decrement once.
  assign inc    = track & ~pending[id_dest];
  assign wb_clr = wb_en & pending[wb_dest] & ~(track & (id_dest == wb_dest));
  assign fl_clr = fl_act & pending[last_dest_q] & ~(wb_en & (wb_dest == last_dest_q));

  assign outstanding_d = outstanding_q + CNT_W'(inc) - CNT_W'(wb_clr) - CNT_W'(fl_clr);
  assign stall_cnt_d   = (hazard && stall_cnt_q != STALL_MAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign last_vld_d    = track;
  assign last_dest_d   = id_dest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      stall_cnt_q   <= '0;
      last_vld_q    <= 1'b0;
      last_dest_q   <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      stall_cnt_q   <= stall_cnt_d;
      last_vld_q    <= last_vld_d;
      last_dest_q   <= last_dest_d;
    end
  end

  assign outstanding = outstanding_q;
  assign stall_cnt   = stall_cnt_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    (outstanding_q == '0) |-> !(wb_clr || fl_clr));
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (forwarding on/off) driven with shared
// directed and random stimulus, checked against a set-of-pending-registers reference model.

module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, two_src, id_issue, id_wb_en, id_mem_r_en, wb_en, flush;
  logic [3:0] src1, src2, id_dest, wb_dest;
  logic haz1, haz0;
  logic [2:0] out1, out0;
  logic [15:0] sc1, sc0;

  int total = 0;
  int bad   = 0;

  // Reference model: index 1 = forwarding instance, index 0 = no-forwarding instance.
  bit pm[2][16];
  bit lv[2];
  int ld[2];
  int sc[2];

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .two_src(two_src), .src1(src1), .src2(src2),
    .id_issue(id_issue), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .flush(flush),
    .hazard(haz1), .outstanding(out1), .stall_cnt(sc1));

  hazard_scoreboard_unit #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .two_src(two_src), .src1(src1), .src2(src2),
    .id_issue(id_issue), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .flush(flush),
    .hazard(haz0), .outstanding(out0), .stall_cnt(sc0));

  function automatic int mcnt(int m);
    int n = 0;
    for (int r = 0; r < 16; r++) n += int'(pm[m][r]);
    return n;
  endfunction

  function automatic bit mvis(int m, int r);
    return pm[m][r] && !(wb_en && int'(wb_dest) == r);
  endfunction

  function automatic bit mhaz(int m);
    bit dep, full, kind;
    if (!rst) return 1'b0;
    kind = (m == 1) ? bit'(id_mem_r_en) : 1'b1;
    dep  = mvis(m, int'(src1)) || (two_src && mvis(m, int'(src2)));
    full = (mcnt(m) == 4) && id_wb_en && kind && !pm[m][id_dest];
    return id_valid && (dep || full);
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 16; r++) pm[m][r] = 1'b0;
      lv[m] = 1'b0;
      ld[m] = 0;
      sc[m] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit h, trk;
    for (int m = 0; m < 2; m++) begin
      h = mhaz(m);
      if (h && sc[m] < 65535) sc[m]++;
      trk = id_issue && id_wb_en && ((m == 1) ? bit'(id_mem_r_en) : 1'b1) && !flush;
      if (wb_en) pm[m][wb_dest] = 1'b0;
      if (flush && lv[m]) pm[m][ld[m]] = 1'b0;
      if (trk) pm[m][id_dest] = 1'b1;
      lv[m] = trk;
      ld[m] = int'(id_dest);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; two_src = 0; src1 = 0; src2 = 0; id_issue = 0; id_wb_en = 0;
    id_mem_r_en = 0; id_dest = 0; wb_en = 0; wb_dest = 0; flush = 0;
  endtask

  task automatic issue_ld(input int r);
    idle();
    id_valid = 1; id_issue = 1; id_wb_en = 1; id_mem_r_en = 1; id_dest = 4'(r);
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, ".haz_fwd"}, 32'(haz1), 32'(mhaz(1)));
    chk({tag, ".haz_nofwd"}, 32'(haz0), 32'(mhaz(0)));
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".out_fwd"}, 32'(out1), 32'(mcnt(1)));
    chk({tag, ".out_nofwd"}, 32'(out0), 32'(mcnt(0)));
    chk({tag, ".sc_fwd"}, 32'(sc1), 32'(sc[1]));
    chk({tag, ".sc_nofwd"}, 32'(sc0), 32'(sc[0]));
  endtask

  initial begin
    rst = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    id_valid = 1; src1 = 4'd3;
    #1;
    chk("rst.haz", 32'(haz1), 0);
    chk("rst.out", 32'(out1), 0);
    chk("rst.sc", 32'(sc1), 0);
    rst = 1;
    idle();

    // 1: load r3 then dependent read; WB of r3 releases the stall in the same cycle
    issue_ld(3); cycle("t1.iss");
    idle(); id_valid = 1; src1 = 4'd3;
    #1 chk("t1.dep", 32'(haz1), 1);
    cycle("t1.dep0"); cycle("t1.dep1");
    wb_en = 1; wb_dest = 4'd3;
    #1 chk("t1.bypass", 32'(haz1), 0);
    cycle("t1.wb");

    // 2: ALU writer r5 is only tracked without forwarding; src2 matters only with two_src
    idle(); id_valid = 1; id_issue = 1; id_wb_en = 1; id_dest = 4'd5;
    cycle("t2.iss");
    idle(); id_valid = 1; src2 = 4'd5;
    #1 chk("t2.one_src", 32'(haz0), 0);
    cycle("t2.one");
    two_src = 1;
    #1 chk("t2.two_src", 32'(haz0), 1);
    chk("t2.fwd_free", 32'(haz1), 0);
    chk("t2.out_nofwd", 32'(out0), 1);
    cycle("t2.two");
    idle(); wb_en = 1; wb_dest = 4'd5; cycle("t2.wb");

    // 3: fill the scoreboard, then a fifth load waits until a slot is actually freed
    for (int r = 1; r <= 4; r++) begin
      issue_ld(r); cycle("t3.fill");
    end
    chk("t3.out4", 32'(out1), 4);
    issue_ld(6); id_issue = 0;
    #1 chk("t3.full", 32'(haz1), 1);
    cycle("t3.full");
    wb_en = 1; wb_dest = 4'd1;
    #1 chk("t3.full_wb", 32'(haz1), 1);
    cycle("t3.wb1");
    wb_en = 0; id_issue = 1;
    #1 chk("t3.freed", 32'(haz1), 0);
    cycle("t3.iss6");
    chk("t3.out_again", 32'(out1), 4);
    for (int k = 0; k < 4; k++) begin
      idle(); wb_en = 1;
      wb_dest = (k == 3) ? 4'd6 : 4'(k + 2);
      cycle("t3.drain");
    end

    // 4: flush cancels the load issued the cycle before
    issue_ld(7); cycle("t4.iss");
    idle(); flush = 1; cycle("t4.flush");
    chk("t4.out", 32'(out1), 0);
    idle(); id_valid = 1; src1 = 4'd7;
    #1 chk("t4.nohaz", 32'(haz1), 0);
    cycle("t4.read");

    // 5: set and WB clear of the same register on one edge: set wins
    issue_ld(2); cycle("t5.iss");
    issue_ld(2); wb_en = 1; wb_dest = 4'd2; cycle("t5.both");
    chk("t5.out", 32'(out1), 1);
    idle(); id_valid = 1; src1 = 4'd2;
    #1 chk("t5.still", 32'(haz1), 1);
    cycle("t5.read");
    idle(); wb_en = 1; wb_dest = 4'd2; cycle("t5.wb");

    // random traffic on a narrow register range so hits and collisions are frequent
    for (int n = 0; n < 400; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      two_src     = 1'($urandom_range(0, 1));
      src1        = 4'($urandom_range(0, 7));
      src2        = 4'($urandom_range(0, 7));
      id_wb_en    = ($urandom_range(0, 3) != 0);
      id_mem_r_en = 1'($urandom_range(0, 1));
      id_dest     = 4'($urandom_range(0, 7));
      wb_en       = ($urandom_range(0, 2) == 0);
      wb_dest     = 4'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 7) == 0);
      id_issue    = !flush && id_valid && !mhaz(0) && !mhaz(1);
      cycle("rnd");
    end

    rst = 0;
    #1;
    model_reset();
    chk("rst2.out_fwd", 32'(out1), 0);
    chk("rst2.out_nofwd", 32'(out0), 0);
    idle();
    @(posedge clk);
    #1 rst = 1;

    // 6: long stall saturates the counter; reset mid-run clears everything at once
    issue_ld(9); cycle("t6.iss");
    idle(); id_valid = 1; src1 = 4'd9;
    for (int n = 0; n < 70000; n++) begin
      @(negedge clk);
      model_edge();
      @(posedge clk);
    end
    #1;
    chk("t6.sat_fwd", 32'(sc1), 65535);
    chk("t6.sat_nofwd", 32'(sc0), 32'(sc[0]));
    chk("t6.haz", 32'(haz1), 1);
    #2 rst = 0;
    #1;
    model_reset();
    chk("t6.rst_haz", 32'(haz1), 0);
    chk("t6.rst_out", 32'(out1), 0);
    chk("t6.rst_sc", 32'(sc1), 0);
    chk("t6.rst_haz0", 32'(haz0), 0);
    @(posedge clk);
    #1 rst = 1;
    #1 chk("t6.no_survivor", 32'(haz1), 0);
    cycle("t6.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
